sram_mem_ctrl: RTL and testbench
================================

SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: cycles each 16-bit SRAM phase is held (1..15).
REQ-002 SHALL have parameter DATA_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en, input, 1: MEM-stage store request.
REQ-006 SHALL have port rd_en, input, 1: MEM-stage load request.
REQ-007 SHALL have port address, input, 32: byte address from the EXE/MEM ALU result.
REQ-008 SHALL have port write_data, input, 32: store data from the EXE/MEM Rm value.
REQ-009 SHALL have port read_data, output, 32: registered load result.
REQ-010 SHALL have port ready, output, 1: access complete; the pipeline freeze equals ~ready.
REQ-011 SHALL have port sram_addr, output, 18: SRAM halfword address.
REQ-012 SHALL have port sram_dq_out, output, 16: SRAM write data.
REQ-013 SHALL have port sram_dq_oe, output, 1: drive enable for sram_dq_out.
REQ-014 SHALL have port sram_dq_in, input, 16: SRAM read data.
REQ-015 SHALL have port sram_we_n, output, 1: SRAM write strobe, active-low.

Function
REQ-016 SHALL implement the FSM states IDLE, LOW, HIGH and DONE.
REQ-017 In IDLE with (wr_en|rd_en)=1, the block SHALL latch address, write_data and op, then move to LOW; if both requests are high, the op SHALL be a write.
REQ-018 Word index SHALL be (address-DATA_BASE)>>2, truncated to 17 bits; the LOW phase SHALL use sram_addr={idx,0} and the HIGH phase {idx,1}.
REQ-019 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles, counted by a 4-bit counter cleared on every state entry.
REQ-020 On writes, LOW SHALL drive sram_dq_out=data[15:0] and HIGH data[31:16], with sram_dq_oe=1 and sram_we_n=0 throughout each phase.
REQ-021 On reads, sram_dq_oe SHALL be 0 and sram_we_n 1, and sram_dq_in SHALL be sampled on the last cycle of LOW into read_data[15:0] and of HIGH into read_data[31:16].
REQ-022 After HIGH, the block SHALL enter DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-023 ready SHALL be combinational: ready = (state==DONE) | ~(wr_en|rd_en).
REQ-024 With WAIT_CYCLES=W, a request first seen in cycle 0 SHALL give ready=1 in cycle 2W+1 and ready=0 in cycles 0..2W.
REQ-025 read_data SHALL hold its value across writes and idle cycles.
REQ-026 Requests deasserting mid-access SHALL NOT abort the access; the block SHALL complete both phases.
REQ-027 In IDLE and DONE, outputs SHALL be sram_we_n=1 and sram_dq_oe=0, and sram_addr SHALL hold its last value.

Reset
REQ-028 rst SHALL force state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0 and sram_we_n=1, immediately and at any point including mid-phase.
REQ-029 After rst deasserts, a held request SHALL start a fresh access from IDLE.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (2-bit), DATA_BASE_DEFAULT=1024 and SRAM_ADDR_W=18.
REQ-031 The block SHALL be a single module with no sub-module; the wait counter SHALL be inline.

Verification
REQ-032 With W=2 and no request: ready=1, sram_we_n=1 and sram_dq_oe=0 on every cycle.
REQ-033 With W=2, write 0xDEADBEEF at 1024: SRAM[0]=0xBEEF and SRAM[1]=0xDEAD; ready=0 in cycles 0..4 and 1 in cycle 5.
REQ-034 With W=2, read at 1024 after REQ-033: read_data=0xDEADBEEF in cycle 5; a write of 0x12345678 at 1028 SHALL hit SRAM[2]=0x5678 and SRAM[3]=0x1234.
REQ-035 With wr_en=rd_en=1, data 0xA5A5_5A5A at 1032: a write SHALL occur to SRAM[4..5], and read_data SHALL be unchanged.
REQ-036 rst pulsed in cycle 2 of a write: sram_we_n=1 immediately, state=IDLE, and a restarted request SHALL complete after a full 2W+1 cycles.
REQ-037 With W=1, back-to-back reads: ready SHALL pulse in cycles 3 and 7, and each read_data SHALL match its word.

Source files
------------

// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM access controller.
package sram_mem_ctrl_pkg;

  localparam int unsigned DATA_BASE_DEFAULT = 1024;
  localparam int unsigned SRAM_ADDR_W       = 18;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned HALF_W            = 16;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned IDX_W             = SRAM_ADDR_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Request captured when an access starts.
  typedef struct packed {
    logic              wr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } req_t;

  // SRAM word index of a byte address relative to the data window base.
  function automatic logic [IDX_W-1:0] word_index(input logic [DATA_W-1:0] address,
                                                  input logic [DATA_W-1:0] base);
    return IDX_W'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two timed 16-bit SRAM phases.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [DATA_W-1:0]      address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [HALF_W-1:0]      sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [HALF_W-1:0]      sram_dq_in,
  output logic                   sram_we_n
);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [DATA_W-1:0] BASE     = DATA_W'(DATA_BASE);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  req_t                   req_q, req_d;
  logic [DATA_W-1:0]      rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_d;
  logic [HALF_W-1:0]      dq_out_d;
  logic                   oe_d;
  logic                   we_n_d;
  logic                   phase_last;

  // Pipeline freeze release: done with the access, or nothing requested.
  assign ready = (state_q == ST_DONE) | ~(wr_en | rd_en);

  // Next state, phase counter and next registered SRAM-side outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = read_data;
    addr_d     = sram_addr;
    dq_out_d   = sram_dq_out;
    oe_d       = 1'b0;
    we_n_d     = 1'b1;
    phase_last = (cnt_q == LAST_CNT);

    case (state_q)
      ST_IDLE: begin
        if (wr_en | rd_en) begin
          state_d    = ST_LOW;
          req_d.wr   = wr_en;
          req_d.idx  = word_index(address, BASE);
          req_d.data = write_data;
        end
      end
      ST_LOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (phase_last) begin
          state_d = ST_HIGH;
          if (!req_q.wr) rdata_d[HALF_W-1:0] = sram_dq_in;
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (phase_last) begin
          state_d = ST_DONE;
          if (!req_q.wr) rdata_d[DATA_W-1:HALF_W] = sram_dq_in;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs are registered, so they are derived from the state being entered.
    case (state_d)
      ST_LOW: begin
        addr_d = {req_d.idx, 1'b0};
        if (req_d.wr) dq_out_d = req_d.data[HALF_W-1:0];
        oe_d   = req_d.wr;
        we_n_d = ~req_d.wr;
      end
      ST_HIGH: begin
        addr_d = {req_d.idx, 1'b1};
        if (req_d.wr) dq_out_d = req_d.data[DATA_W-1:HALF_W];
        oe_d   = req_d.wr;
        we_n_d = ~req_d.wr;
      end
      default: ;
    endcase
  end

  // State register and registered outputs; reset acts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      read_data   <= rdata_d;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= oe_d;
      sram_we_n   <= we_n_d;
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl with behavioural SRAMs and a word-level model.
module tb_sram_mem_ctrl;

  localparam int unsigned W2   = 2;
  localparam int unsigned W1   = 1;
  localparam int unsigned BASE = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic mem_clr;

  // Instance with WAIT_CYCLES=2
  logic        wr_en, rd_en, ready, sram_dq_oe, sram_we_n;
  logic [31:0] address, write_data, read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  // Instance with WAIT_CYCLES=1
  logic        wr_en_b, rd_en_b, ready_b, sram_dq_oe_b, sram_we_n_b;
  logic [31:0] address_b, write_data_b, read_data_b;
  logic [17:0] sram_addr_b;
  logic [15:0] sram_dq_out_b, sram_dq_in_b;

  sram_mem_ctrl #(.WAIT_CYCLES(W2), .DATA_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(W1), .DATA_BASE(BASE)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .rd_en(rd_en_b), .address(address_b),
    .write_data(write_data_b), .read_data(read_data_b), .ready(ready_b),
    .sram_addr(sram_addr_b), .sram_dq_out(sram_dq_out_b), .sram_dq_oe(sram_dq_oe_b),
    .sram_dq_in(sram_dq_in_b), .sram_we_n(sram_we_n_b)
  );

  // Behavioural asynchronous-read SRAMs, written on the clock while we_n is low
  logic [15:0] sram_mem   [0:255];
  logic [15:0] sram_mem_b [0:255];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        sram_mem[i]   <= '0;
        sram_mem_b[i] <= '0;
      end
    end else begin
      if (!sram_we_n)   sram_mem[sram_addr[7:0]]     <= sram_dq_out;
      if (!sram_we_n_b) sram_mem_b[sram_addr_b[7:0]] <= sram_dq_out_b;
    end
  end

  assign sram_dq_in   = sram_mem[sram_addr[7:0]];
  assign sram_dq_in_b = sram_mem_b[sram_addr_b[7:0]];

  // Word-level reference model
  logic [31:0] ref2 [0:63];
  logic [31:0] ref1 [0:63];
  logic [31:0] exp_rd2, exp_rd1;

  int checks = 0;
  int errors = 0;

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[18:2]);
  endfunction

  // One complete access on the W=2 instance, checked cycle by cycle
  task automatic access2(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input string tag);
    int          cyc, we_cnt, oe_cnt, idx;
    logic        done, exp_rdy;
    logic [17:0] lo_addr, hi_addr;
    idx     = widx(addr);
    lo_addr = {17'(idx), 1'b0};
    hi_addr = {17'(idx), 1'b1};
    if (wr) ref2[idx % 64] = data;
    else if (rd) exp_rd2 = ref2[idx % 64];
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    cyc = 0; we_cnt = 0; oe_cnt = 0; done = 1'b0;
    while (!done) begin
      #1;
      exp_rdy = (cyc == 2 * W2 + 1);
      checks++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s ready cycle %0d got %b expected %b", tag, cyc, ready, exp_rdy);
      end
      if (cyc == 1 || cyc == W2 + 1) begin
        checks++;
        if (sram_addr !== (cyc == 1 ? lo_addr : hi_addr)) begin
          errors++;
          $display("FAIL %s sram_addr cycle %0d got %h expected %h", tag, cyc, sram_addr,
                   (cyc == 1 ? lo_addr : hi_addr));
        end
      end
      if (!sram_we_n) we_cnt++;
      if (sram_dq_oe) oe_cnt++;
      if (ready === 1'b1 || cyc >= 2 * W2 + 3) begin
        done = 1'b1;
        checks++;
        if (read_data !== exp_rd2) begin
          errors++;
          $display("FAIL %s read_data got %h expected %h", tag, read_data, exp_rd2);
        end
        checks++;
        if (we_cnt != (wr ? 2 * W2 : 0) || oe_cnt != (wr ? 2 * W2 : 0)) begin
          errors++;
          $display("FAIL %s strobe cycles we %0d oe %0d expected %0d", tag, we_cnt, oe_cnt,
                   (wr ? 2 * W2 : 0));
        end
        if (wr) begin
          checks++;
          if ({sram_mem[2*idx+1], sram_mem[2*idx]} !== data) begin
            errors++;
            $display("FAIL %s sram word %0d got %h%h expected %h", tag, idx,
                     sram_mem[2*idx+1], sram_mem[2*idx], data);
          end
        end
        wr_en = 1'b0; rd_en = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Two accesses on the W=1 instance with the request held continuously
  task automatic b2b1(input logic wr, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input string tag);
    logic exp_rdy;
    if (wr) begin
      ref1[widx(a0) % 64] = d0;
      ref1[widx(a1) % 64] = d1;
    end
    wr_en_b = wr; rd_en_b = ~wr; address_b = a0; write_data_b = d0;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      #1;
      exp_rdy = (cyc == 3 || cyc == 7);
      checks++;
      if (ready_b !== exp_rdy) begin
        errors++;
        $display("FAIL %s ready cycle %0d got %b expected %b", tag, cyc, ready_b, exp_rdy);
      end
      if (cyc == 3 || cyc == 7) begin
        if (!wr) exp_rd1 = ref1[widx(cyc == 3 ? a0 : a1) % 64];
        checks++;
        if (read_data_b !== exp_rd1) begin
          errors++;
          $display("FAIL %s read_data cycle %0d got %h expected %h", tag, cyc, read_data_b, exp_rd1);
        end
        address_b = a1; write_data_b = d1;
        if (cyc == 7) begin wr_en_b = 1'b0; rd_en_b = 1'b0; end
      end
      @(posedge clk); #1;
    end
    if (wr) begin
      checks++;
      if ({sram_mem_b[2*widx(a1)+1], sram_mem_b[2*widx(a1)]} !== d1 ||
          {sram_mem_b[2*widx(a0)+1], sram_mem_b[2*widx(a0)]} !== d0) begin
        errors++;
        $display("FAIL %s sram words got %h%h %h%h expected %h %h", tag,
                 sram_mem_b[2*widx(a0)+1], sram_mem_b[2*widx(a0)],
                 sram_mem_b[2*widx(a1)+1], sram_mem_b[2*widx(a1)], d0, d1);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_clr = 1'b1;
    wr_en = 0; rd_en = 0; address = '0; write_data = '0;
    wr_en_b = 0; rd_en_b = 0; address_b = '0; write_data_b = '0;
    for (int i = 0; i < 64; i++) begin ref2[i] = '0; ref1[i] = '0; end
    exp_rd2 = '0; exp_rd1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (read_data !== 32'h0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0 ||
        sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset outputs got rd %h addr %h dq %h oe %b we_n %b ready %b", read_data,
               sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, ready);
    end
    checks++;
    if (read_data_b !== 32'h0 || sram_we_n_b !== 1'b1 || sram_dq_oe_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b outputs got rd %h we_n %b oe %b", read_data_b, sram_we_n_b, sram_dq_oe_b);
    end
    rst = 1'b0; mem_clr = 1'b0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
        errors++;
        $display("FAIL idle cycle %0d got ready %b we_n %b oe %b expected 1 1 0", i, ready,
                 sram_we_n, sram_dq_oe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_directed;
    access2(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "write_deadbeef");
    access2(1'b0, 1'b1, 32'd1024, 32'h0, "read_deadbeef");
    access2(1'b1, 1'b0, 32'd1028, 32'h12345678, "write_1028");
    access2(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, "write_and_read");
    access2(1'b1, 1'b0, 32'd1024 + 32'h0008_0000, 32'h0BADF00D, "write_index_wrap");
    access2(1'b0, 1'b1, 32'd1024, 32'h0, "read_after_wrap");
    access2(1'b0, 1'b1, 32'd1028, 32'h0, "read_1028");
  endtask

  task automatic test_reset_mid;
    logic [31:0] data;
    data = $urandom;
    wr_en = 1'b1; rd_en = 1'b0; address = BASE + 40; write_data = data;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'h0 ||
        sram_addr !== 18'h0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got we_n %b oe %b rd %h addr %h ready %b", sram_we_n, sram_dq_oe,
               read_data, sram_addr, ready);
    end
    exp_rd2 = '0; exp_rd1 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    access2(1'b1, 1'b0, BASE + 40, data, "restart_write");
    access2(1'b0, 1'b1, BASE + 40, 32'h0, "restart_read");
  endtask

  task automatic test_random;
    int          op, idx;
    logic [31:0] addr;
    for (int n = 0; n < 24; n++) begin
      op   = $urandom_range(0, 2);
      idx  = $urandom_range(0, 63);
      addr = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      access2(op != 1, op != 0, addr, $urandom, "random");
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_back_to_back;
    int i0, i1;
    i0 = $urandom_range(0, 15);
    i1 = (i0 + 1 + $urandom_range(0, 13)) % 16;
    b2b1(1'b1, BASE + 32'(i0 * 4), BASE + 32'(i1 * 4), $urandom, $urandom, "b2b_write");
    b2b1(1'b0, BASE + 32'(i0 * 4), BASE + 32'(i1 * 4), 32'h0, 32'h0, "b2b_read");
    b2b1(1'b0, BASE + 32'(i1 * 4), BASE + 32'(i0 * 4), 32'h0, 32'h0, "b2b_read_swap");
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_idle();
    test_directed();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
